accumulator_sequencer: RTL
==========================

# accumulator_sequencer

Control FSM for the output-stationary Accumulator bank. Per job: clears the bank, steers each incoming partial-sum vector from the systolic array into its accumulator row over a programmable number of passes, then drains the finished rows to the writeback path over a valid/ready stream. Sits between the array's psum output, the Accumulator's control/selector inputs, and the output writeback stage.

## Interface
- SELECTOR_WIDTH, 12, width of the accumulator row selectors
- NO_VECTORS, 4096, number of accumulator rows
- PASS_WIDTH, 16, width of the pass count
- CLK  in  1  clock; one clock, reset SYNC_RST_N is synchronous and active-low
- SYNC_RST_N  in  1  synchronous active-low reset
- Start  in  1  job start; sampled only in IDLE
- BaseVector  in  SELECTOR_WIDTH  first row of the job
- NumVectors  in  SELECTOR_WIDTH+1  rows per pass (0..NO_VECTORS)
- NumPasses  in  PASS_WIDTH  accumulation passes (0..2^PASS_WIDTH-1)
- Psum_Valid  in  1  array presents one psum vector
- Psum_Ready  out  1  sequencer accepts psum vector
- Acc_EN  out  1  to Accumulator EN
- Acc_Clear  out  1  to Accumulator SYNC_RST
- WriteVectorSelector  out  SELECTOR_WIDTH  to Accumulator
- ReadVectorSelector  out  SELECTOR_WIDTH  to Accumulator
- Out_Valid  out  1  ReadVector holds a finished row
- Out_Ready  in  1  writeback accepts row
- Out_Last  out  1  final row of job
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, CLEAR, ACCUM, PRIME, DRAIN, DONE.
- IDLE: on Start capture config (NumVectors > NO_VECTORS clamps to NO_VECTORS). If captured NumVectors==0 or NumPasses==0 -> DONE; else -> CLEAR. Start outside IDLE ignored.
- CLEAR: Acc_Clear=1 for exactly one cycle -> ACCUM.
- ACCUM: Psum_Ready=1. Acc_EN = Psum_Valid (combinational, ACCUM only). WriteVectorSelector = BaseVector + vec_cnt, truncated to SELECTOR_WIDTH (wraps). On accept: vec_cnt++; at NumVectors-1 vec_cnt->0 and pass_cnt++. Accept of last row of last pass -> PRIME.
- PRIME: ReadVectorSelector = BaseVector; Out_Valid=0; one cycle -> DRAIN.
- DRAIN: Out_Valid=1; rd_cnt = row currently on ReadVector. ReadVectorSelector = BaseVector + rd_cnt + (Out_Valid & Out_Ready) (combinational look-ahead, truncated). Out_Last = (rd_cnt == NumVectors-1). Handshake increments rd_cnt; handshake with Out_Last -> DONE.
- DONE: Done=1 one cycle -> IDLE.
- Outside their states: Psum_Ready, Acc_EN, Acc_Clear, Out_Valid, Out_Last, Done = 0; selectors hold last value.

## Timing
- Reset (SYNC_RST_N=0 at edge): state IDLE, all counters 0, every output 0 (selectors 0). Reset mid-job aborts it: no Done, Accumulator contents undefined; no Acc_Clear issued.
- Accumulator read latency is fixed at 1 cycle (registered ReadVector); write accumulates on the edge where Acc_EN=1.
- Start -> Acc_Clear: 1 cycle; first Psum_Ready: 2 cycles after Start edge.
- Last psum accept -> first Out_Valid: 2 cycles. Drain throughput 1 row/cycle under continuous Out_Ready; Out_Valid never drops mid-drain; ReadVector stable while Out_Valid & !Out_Ready.
- Last drain handshake -> Done the next cycle; Busy falls the cycle after Done; new Start accepted the cycle Busy=0.
- Zero-size job: Start -> Done 1 cycle later, no Acc_Clear/Acc_EN/Out_Valid.
- Psum_Valid outside ACCUM: ignored, no write.

## Configuration
- ACC_SEQ_ABORT_EN defined: adds input Abort (1 bit). Abort=1 in any state except IDLE -> Acc_Clear=1 that cycle, next state IDLE, no Done, in-flight Psum/Out handshake that cycle is suppressed (Acc_EN=0, Out_Valid=0). Abort in IDLE ignored; Abort and Start together in IDLE -> Start wins.
- Not defined: no Abort port; a job runs to completion or reset.

## Test plan
- Base=0, NumVectors=4, NumPasses=3, Psum_Valid always 1, Out_Ready always 1 -> one Acc_Clear, 12 Acc_EN with selectors 0,1,2,3 x3, drain rows 0..3 on 4 consecutive cycles, Out_Last on row 3, Done 1 cycle later.
- Base=4094, NumVectors=4, NumPasses=1 -> WriteVectorSelector 4094,4095,0,1; ReadVector drained in same order.
- Psum_Valid toggling 1/0 and Out_Ready random 50% -> Acc_EN only on Psum_Valid cycles, no dropped or repeated drain rows, ReadVector stable while stalled.
- NumPasses=0 or NumVectors=0 -> Done exactly 1 cycle after Start, no Acc_Clear/Acc_EN/Out_Valid; NumVectors=5000 -> clamped to 4096 rows.
- SYNC_RST_N pulsed low during DRAIN row 2 -> all outputs 0 next cycle, no Done; fresh job runs normally; Start while Busy ignored.
- With ACC_SEQ_ABORT_EN: Abort in ACCUM after 5 accepts -> Acc_Clear same cycle, IDLE next, no Done, Busy=0.

Source files
------------

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer
// Control FSM for the output-stationary accumulator bank. Per job it
// clears the bank, steers every incoming psum vector into its row for a
// programmable number of passes, then drains the finished rows over a
// valid/ready stream with a one-cycle read-latency look-ahead.
// Optional feature macro: ACC_SEQ_ABORT_EN (adds the Abort input).
module accumulator_sequencer #(
    parameter int SELECTOR_WIDTH = 12,
    parameter int NO_VECTORS     = 4096,
    parameter int PASS_WIDTH     = 16
) (
    input  logic                      CLK,
    input  logic                      SYNC_RST_N,
    input  logic                      Start,
    input  logic [SELECTOR_WIDTH-1:0] BaseVector,
    input  logic [SELECTOR_WIDTH:0]   NumVectors,
    input  logic [PASS_WIDTH-1:0]     NumPasses,
`ifdef ACC_SEQ_ABORT_EN
    input  logic                      Abort,
`endif
    input  logic                      Psum_Valid,
    output logic                      Psum_Ready,
    output logic                      Acc_EN,
    output logic                      Acc_Clear,
    output logic [SELECTOR_WIDTH-1:0] WriteVectorSelector,
    output logic [SELECTOR_WIDTH-1:0] ReadVectorSelector,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic                      Out_Last,
    output logic                      Busy,
    output logic                      Done
);

    localparam int SW = SELECTOR_WIDTH;
    localparam int PW = PASS_WIDTH;
    localparam logic [SW:0] LP_MAX_VEC = (SW+1)'(NO_VECTORS);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_PRIME, S_DRAIN, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [SW-1:0] r_base, r_vec_cnt, r_rd_cnt, r_wsel, r_rsel;
    logic [SW-1:0] w_wsel, w_rsel;
    logic [SW:0]   r_num, w_num_in, w_num_m1;
    logic [PW-1:0] r_passes, r_pass_cnt;
    logic          w_abort, w_vec_last, w_pass_last, w_rd_last;

`ifdef ACC_SEQ_ABORT_EN
    assign w_abort = Abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Oversized jobs are clamped to the physical bank depth at capture.
    assign w_num_in    = (NumVectors > LP_MAX_VEC) ? LP_MAX_VEC : NumVectors;
    assign w_num_m1    = r_num - (SW+1)'(1);
    assign w_vec_last  = ({1'b0, r_vec_cnt} == w_num_m1);
    assign w_rd_last   = ({1'b0, r_rd_cnt} == w_num_m1);
    assign w_pass_last = (r_pass_cnt == (r_passes - PW'(1)));

    assign WriteVectorSelector = w_wsel;
    assign ReadVectorSelector  = w_rsel;
    assign Busy                = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next state and per-state outputs; selectors hold their last value
    // outside the states that drive them.
    always_comb begin
        w_next     = r_state;
        Psum_Ready = 1'b0;
        Acc_EN     = 1'b0;
        Acc_Clear  = 1'b0;
        Out_Valid  = 1'b0;
        Out_Last   = 1'b0;
        Done       = 1'b0;
        w_wsel     = r_wsel;
        w_rsel     = r_rsel;
        if (w_abort) begin
            // Abort wipes the bank and suppresses any handshake this cycle.
            Acc_Clear = 1'b1;
            w_next    = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start)
                        w_next = (w_num_in == '0 || NumPasses == '0) ? S_DONE : S_CLEAR;
                end
                S_CLEAR: begin
                    Acc_Clear = 1'b1;
                    w_next    = S_ACCUM;
                end
                S_ACCUM: begin
                    Psum_Ready = 1'b1;
                    Acc_EN     = Psum_Valid;
                    w_wsel     = r_base + r_vec_cnt;
                    if (Psum_Valid && w_vec_last && w_pass_last)
                        w_next = S_PRIME;
                end
                S_PRIME: begin
                    // Preload the first row so it is on ReadVector in DRAIN.
                    w_rsel = r_base;
                    w_next = S_DRAIN;
                end
                S_DRAIN: begin
                    Out_Valid = 1'b1;
                    Out_Last  = w_rd_last;
                    // Look one row ahead on a handshake to hide read latency.
                    w_rsel    = r_base + r_rd_cnt + SW'(Out_Ready);
                    if (Out_Ready && w_rd_last)
                        w_next = S_DONE;
                end
                S_DONE: begin
                    Done   = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Job configuration capture, row/pass/drain counters, selector hold.
    always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
            r_base     <= '0;
            r_num      <= '0;
            r_passes   <= '0;
            r_vec_cnt  <= '0;
            r_pass_cnt <= '0;
            r_rd_cnt   <= '0;
            r_wsel     <= '0;
            r_rsel     <= '0;
        end else begin
            r_wsel <= w_wsel;
            r_rsel <= w_rsel;
            if (r_state == S_IDLE && Start) begin
                r_base     <= BaseVector;
                r_num      <= w_num_in;
                r_passes   <= NumPasses;
                r_vec_cnt  <= '0;
                r_pass_cnt <= '0;
                r_rd_cnt   <= '0;
            end
            if (Acc_EN) begin
                if (w_vec_last) begin
                    r_vec_cnt  <= '0;
                    r_pass_cnt <= r_pass_cnt + PW'(1);
                end else begin
                    r_vec_cnt  <= r_vec_cnt + SW'(1);
                end
            end
            if (Out_Valid && Out_Ready)
                r_rd_cnt <= r_rd_cnt + SW'(1);
        end
    end

endmodule
